// File: rtl/logic_sweep_pkg.sv
// Shared definitions for the logic sweep/capture stage.
//   - FSM state encoding (2-bit)
//   - stimulus width N_IN and truth-table width TBL_W
//   - MADAR_EXPECT: golden truth table of the Madar_Mantegi block
//   - lowest_set(): priority encoder, lowest set bit wins
package logic_sweep_pkg;

  localparam int unsigned N_IN  = 3;
  localparam int unsigned TBL_W = 8;

  localparam logic [TBL_W-1:0] MADAR_EXPECT = 8'hFA;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StDrive  = 2'd1;  // vectors 0..6
  localparam state_t StLast   = 2'd2;  // vector 7
  localparam state_t StReport = 2'd3;

  // Index of the lowest set bit; 0 when v is all zero.
  function automatic logic [N_IN-1:0] lowest_set(input logic [TBL_W-1:0] v);
    logic [N_IN-1:0] idx;
    idx = '0;
    for (int i = TBL_W - 1; i >= 0; i--) begin
      if (v[i]) idx = N_IN'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/logic_sweep_capture_settle_timer.sv
// Loadable down-counter used to hold each stimulus vector for a fixed time.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   load_i  : load value_i into the counter (has priority over counting)
//   value_i : load value
//   zero_o  : counter is zero; counting stops at zero
module logic_sweep_capture_settle_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/logic_sweep_capture.sv
// Stimulus/capture stage around a 3-input combinational block. Steps {A,B,C}
// through 0..7, holds each vector SETTLE cycles, samples X at the last edge of
// each window into TABLE, then compares TABLE with the EXPECT value latched at
// START and reports MISMATCH / FIRST_BAD with a one-cycle DONE pulse.
//   CLK, RST_N : clock, asynchronous active-low reset
//   START      : sweep request, accepted only in idle and not in the DONE cycle
//   EXPECT     : expected truth table (bit i for {A,B,C}=i), latched at START
//   X          : output of the block under test
//   A, B, C    : stimulus vector (A is the MSB)
//   BUSY, DONE : sweep in progress / sweep complete pulse
//   TABLE      : captured truth table
//   MISMATCH   : TABLE differs from latched EXPECT
//   FIRST_BAD  : lowest differing index, 0 when none
module logic_sweep_capture
  import logic_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 2  // cycles per vector, 1..15
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [TBL_W-1:0] EXPECT,
  input  logic             X,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             BUSY,
  output logic             DONE,
  output logic [TBL_W-1:0] TABLE,
  output logic             MISMATCH,
  output logic [N_IN-1:0]  FIRST_BAD
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [N_IN-1:0]  idx_q;
  logic [N_IN-1:0]  abc_q;
  logic [TBL_W-1:0] exp_q;
  logic [TBL_W-1:0] table_q;
  logic             busy_q;
  logic             done_q;
  logic             mismatch_q;
  logic [N_IN-1:0]  first_bad_q;

  logic             cnt_zero;
  logic             start_ok;
  logic             capture;
  logic             timer_load;
  logic [TBL_W-1:0] diff;

  // The DONE cycle is already idle, but a START seen there is still ignored
  // so a held START cannot produce back-to-back DONE pulses.
  assign start_ok   = (state_q == StIdle) && START && !done_q;
  assign capture    = ((state_q == StDrive) || (state_q == StLast)) && cnt_zero;
  assign timer_load = start_ok || (capture && (state_q == StDrive));
  assign diff       = table_q ^ exp_q;

  logic_sweep_capture_settle_timer #(
    .Width (CntW)
  ) u_settle_timer (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .load_i  (timer_load),
    .value_i (SettleLoad),
    .zero_o  (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_ok) state_d = StDrive;
      StDrive:  if (capture && (idx_q == 3'd6)) state_d = StLast;
      StLast:   if (capture) state_d = StReport;
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      abc_q       <= '0;
      exp_q       <= '0;
      table_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            exp_q       <= EXPECT;
            idx_q       <= '0;
            abc_q       <= '0;
            table_q     <= '0;
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        StDrive, StLast: begin
          if (capture) begin
            table_q[idx_q] <= X;
            // Vector 7 stays on the pins through the report cycle.
            if (state_q == StDrive) begin
              idx_q <= idx_q + 3'd1;
              abc_q <= idx_q + 3'd1;
            end
          end
        end
        StReport: begin
          mismatch_q  <= |diff;
          first_bad_q <= lowest_set(diff);
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          abc_q       <= '0;
          idx_q       <= '0;
        end
        default: ;
      endcase
    end
  end

  assign A         = abc_q[2];
  assign B         = abc_q[1];
  assign C         = abc_q[0];
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign TABLE     = table_q;
  assign MISMATCH  = mismatch_q;
  assign FIRST_BAD = first_bad_q;

endmodule

// File: tb/tb_logic_sweep_capture.sv
// Bench for logic_sweep_capture: one instance with SETTLE=2 driving a model of
// Madar_Mantegi (X = A | C, table 8'hFA) and one with SETTLE=1 and X tied low.
module tb_logic_sweep_capture;
  import logic_sweep_pkg::*;

  typedef struct packed {
    logic [7:0] tbl;
    logic       mm;
    logic [2:0] fb;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] expect_in = 8'h00;
  logic       sel = 1'b0;  // 0: SETTLE=2 instance, 1: SETTLE=1 instance

  logic       a2, b2, c2, busy2, done2, mm2, x2;
  logic [7:0] tbl2;
  logic [2:0] fb2;
  logic       a1, b1, c1, busy1, done1, mm1;
  logic       x1 = 1'b0;
  logic [7:0] tbl1;
  logic [2:0] fb1;
  logic       start2, start1;

  logic       v_a, v_b, v_c, v_busy, v_done, v_mm;
  logic [7:0] v_tbl;
  logic [2:0] v_fb;

  int  n_tests = 0;
  int  n_fail  = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  assign x2     = a2 | c2;
  assign start2 = start & ~sel;
  assign start1 = start & sel;

  assign v_a    = sel ? a1 : a2;
  assign v_b    = sel ? b1 : b2;
  assign v_c    = sel ? c1 : c2;
  assign v_busy = sel ? busy1 : busy2;
  assign v_done = sel ? done1 : done2;
  assign v_mm   = sel ? mm1 : mm2;
  assign v_tbl  = sel ? tbl1 : tbl2;
  assign v_fb   = sel ? fb1 : fb2;

  logic_sweep_capture #(.SETTLE(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .EXPECT(expect_in), .X(x2),
    .A(a2), .B(b2), .C(c2), .BUSY(busy2), .DONE(done2), .TABLE(tbl2),
    .MISMATCH(mm2), .FIRST_BAD(fb2)
  );

  logic_sweep_capture #(.SETTLE(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .EXPECT(expect_in), .X(x1),
    .A(a1), .B(b1), .C(c1), .BUSY(busy1), .DONE(done1), .TABLE(tbl1),
    .MISMATCH(mm1), .FIRST_BAD(fb1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result of a sweep on the selected instance.
  function automatic sb_t model(input logic [7:0] exp, input logic which);
    sb_t r;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      r.tbl[i] = which ? 1'b0 : (v[2] | v[0]);
    end
    d    = r.tbl ^ exp;
    r.mm = |d;
    r.fb = 3'd0;
    for (int i = 7; i >= 0; i--) if (d[i]) r.fb = 3'(i);
    return r;
  endfunction

  // Called at the first negedge after the accepting edge.
  task automatic track(input logic [7:0] exp, input bit hold, input bit repulse);
    int  s;
    int  n;
    sb_t e;
    s = sel ? 1 : 2;
    n = 0;
    check("busy_start", {31'd0, v_busy}, 1);
    while (!v_done && n < 8 * s + 8) begin
      if (n < 8 * s) check("abc", {29'd0, v_a, v_b, v_c}, n / s);
      if (repulse && n == 5) start = 1'b1;
      if (repulse && n == 6) start = 1'b0;
      if (n == 2) expect_in = ~exp;  // must be ignored by the running sweep
      @(negedge clk);
      n++;
    end
    check("done_latency", n, 8 * s + 1);
    check("busy_at_done", {31'd0, v_busy}, 0);
    check("abc_at_done", {29'd0, v_a, v_b, v_c}, 0);
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("table", {24'd0, v_tbl}, {24'd0, e.tbl});
      check("mismatch", {31'd0, v_mm}, {31'd0, e.mm});
      check("first_bad", {29'd0, v_fb}, {29'd0, e.fb});
    end
    @(negedge clk);
    check("done_one_cycle", {31'd0, v_done}, 0);
    if (!hold) check("idle_after", {31'd0, v_busy}, 0);
  endtask

  task automatic run_sweep(input logic [7:0] exp, input bit hold, input bit repulse);
    @(negedge clk);
    expect_in = exp;
    start     = 1'b1;
    sb.push_back(model(exp, sel));
    @(negedge clk);
    if (!hold) start = 1'b0;
    track(exp, hold, repulse);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check("rst_busy", {31'd0, busy2}, 0);
    check("rst_done", {31'd0, done2}, 0);
    check("rst_abc", {29'd0, a2, b2, c2}, 0);
    check("rst_table", {24'd0, tbl2}, 0);
    check("rst_mm_fb", {28'd0, mm2, fb2}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Golden match, then a single-bit disagreement at index 1
    sel = 1'b0;
    run_sweep(MADAR_EXPECT, 0, 0);
    run_sweep(8'hF8, 0, 0);
    repeat (3) @(negedge clk);
    check("hold_table", {24'd0, tbl2}, 32'hFA);
    check("hold_mm_fb", {28'd0, mm2, fb2}, {28'd0, 1'b1, 3'd1});

    // SETTLE=1, X low
    sel = 1'b1;
    run_sweep(8'h00, 0, 0);
    run_sweep(8'h80, 0, 0);

    // START re-pulsed mid-sweep, then START held through DONE
    sel = 1'b0;
    run_sweep(MADAR_EXPECT, 0, 1);
    run_sweep(MADAR_EXPECT, 1, 0);
    begin
      int k;
      k = 0;
      while (!v_busy && k < 4) begin
        @(negedge clk);
        k++;
      end
      check("held_restart", {31'd0, v_busy}, 1);
      start = 1'b0;
      sb.push_back(model(expect_in, sel));
      track(expect_in, 0, 0);
    end

    // Reset during vector 3
    @(negedge clk);
    expect_in = MADAR_EXPECT;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_abc", {29'd0, a2, b2, c2}, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy2}, 0);
    check("mid_rst_abc", {29'd0, a2, b2, c2}, 0);
    check("mid_rst_table", {24'd0, tbl2}, 0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_done", {31'd0, done2}, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_done", {31'd0, done2}, 0);
    run_sweep(MADAR_EXPECT, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
